// File: rtl/aes_selftest_seq.sv
// AES known-answer self-test sequencer: pulses encrypt then decrypt core loads
// (stretched to one slow-clock period), checks results and reports sticky status.
module aes_selftest_seq #(
    parameter int DIV     = 4,
    parameter int TIMEOUT = 1024,
    parameter int CNTW    = 11
) (
    input  logic         fclk,
    input  logic         reset_n,
    input  logic         start,
    input  logic [127:0] exp_ct,
    input  logic [127:0] exp_pt,
    input  logic [127:0] enc_ct,
    input  logic         enc_valid,
    input  logic [127:0] dec_pt,
    input  logic         dec_valid,
    output logic         enc_load,
    output logic         dec_load,
    output logic         busy,
    output logic         done,
    output logic         pass_enc,
    output logic         pass_dec,
    output logic         fail,
    output logic         timeout
);

    // state      | meaning
    // S_IDLE     | waiting for first start edge
    // S_ENC_LOAD | enc_load held for DIV cycles
    // S_ENC_WAIT | waiting for armed enc_valid or timeout
    // S_DEC_LOAD | dec_load held for DIV cycles
    // S_DEC_WAIT | waiting for armed dec_valid or timeout
    // S_DONE     | status held, new start edge restarts
    typedef enum logic [2:0] {
        S_IDLE,
        S_ENC_LOAD,
        S_ENC_WAIT,
        S_DEC_LOAD,
        S_DEC_WAIT,
        S_DONE
    } state_t;

    localparam logic [CNTW-1:0] LD_INIT = CNTW'(DIV - 1);
    localparam logic [CNTW-1:0] TO_INIT = CNTW'(TIMEOUT - 1);
    localparam logic [CNTW-1:0] CNT_ONE = CNTW'(1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CNTW-1:0]   r_cnt;
    logic [CNTW-1:0]   w_cnt_nxt;
    logic              r_armed;
    logic              w_armed_nxt;
    logic              r_sync1;
    logic              r_sync2;
    logic              r_sync3;
    logic              w_trig;
    logic              w_enc_phase;
    logic              w_valid;
    logic              w_match;
    logic              r_enc_load;
    logic              r_dec_load;
    logic              r_busy;
    logic              r_done;
    logic              r_pass_enc;
    logic              r_pass_dec;
    logic              r_fail;
    logic              r_timeout;
    logic              w_pass_enc_nxt;
    logic              w_pass_dec_nxt;
    logic              w_fail_nxt;
    logic              w_timeout_nxt;

    assign w_trig      = r_sync2 & ~r_sync3;
    assign w_enc_phase = (r_state == S_ENC_LOAD) || (r_state == S_ENC_WAIT);
    assign w_valid     = w_enc_phase ? enc_valid : dec_valid;
    assign w_match     = w_enc_phase ? (enc_ct == exp_ct) : (dec_pt == exp_pt);

    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_armed_nxt    = r_armed;
        w_pass_enc_nxt = r_pass_enc;
        w_pass_dec_nxt = r_pass_dec;
        w_fail_nxt     = r_fail;
        w_timeout_nxt  = r_timeout;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (w_trig) begin
                    w_state_nxt    = S_ENC_LOAD;
                    w_cnt_nxt      = LD_INIT;
                    w_armed_nxt    = 1'b0;
                    w_pass_enc_nxt = 1'b0;
                    w_pass_dec_nxt = 1'b0;
                    w_fail_nxt     = 1'b0;
                    w_timeout_nxt  = 1'b0;
                end
            end
            S_ENC_LOAD, S_DEC_LOAD: begin
                if (!w_valid) w_armed_nxt = 1'b1;
                if (r_cnt == '0) begin
                    w_state_nxt = (r_state == S_ENC_LOAD) ? S_ENC_WAIT : S_DEC_WAIT;
                    w_cnt_nxt   = TO_INIT;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_ONE;
                end
            end
            S_ENC_WAIT, S_DEC_WAIT: begin
                if (!w_valid) w_armed_nxt = 1'b1;
                // a valid result wins over a simultaneous timeout
                if (r_armed && w_valid) begin
                    w_fail_nxt = r_fail | ~w_match;
                    if (r_state == S_ENC_WAIT) begin
                        w_pass_enc_nxt = w_match;
                        w_state_nxt    = S_DEC_LOAD;
                        w_cnt_nxt      = LD_INIT;
                        w_armed_nxt    = 1'b0;
                    end else begin
                        w_pass_dec_nxt = w_match;
                        w_state_nxt    = S_DONE;
                    end
                end else if (r_cnt == '0) begin
                    w_timeout_nxt = 1'b1;
                    w_fail_nxt    = 1'b1;
                    w_state_nxt   = S_DONE;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_ONE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge fclk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_armed    <= 1'b0;
            r_sync1    <= 1'b0;
            r_sync2    <= 1'b0;
            r_sync3    <= 1'b0;
            r_enc_load <= 1'b0;
            r_dec_load <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_pass_enc <= 1'b0;
            r_pass_dec <= 1'b0;
            r_fail     <= 1'b0;
            r_timeout  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_armed    <= w_armed_nxt;
            r_sync1    <= start;
            r_sync2    <= r_sync1;
            r_sync3    <= r_sync2;
            r_enc_load <= (w_state_nxt == S_ENC_LOAD);
            r_dec_load <= (w_state_nxt == S_DEC_LOAD);
            r_busy     <= (w_state_nxt != S_IDLE) && (w_state_nxt != S_DONE);
            r_done     <= (w_state_nxt == S_DONE);
            r_pass_enc <= w_pass_enc_nxt;
            r_pass_dec <= w_pass_dec_nxt;
            r_fail     <= w_fail_nxt;
            r_timeout  <= w_timeout_nxt;
        end
    end

    assign enc_load = r_enc_load;
    assign dec_load = r_dec_load;
    assign busy     = r_busy;
    assign done     = r_done;
    assign pass_enc = r_pass_enc;
    assign pass_dec = r_pass_dec;
    assign fail     = r_fail;
    assign timeout  = r_timeout;

endmodule
